// File: rtl/nco_voice_scheduler.sv
// Slot sequencer for the time-multiplexed NCO: walks (vx,ox) and turns queued
// phase-reset requests into whole-pass accumulator-zero flags for each voice.
module nco_voice_scheduler #(
  parameter int VOICES  = 8,
  parameter int V_OSC   = 4,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2,
  parameter int V_ENVS  = 8
) (
  input  logic               sCLK_XVXENVS,
  input  logic               reset_reg_N,
  input  logic               run,
  input  logic               req_valid,
  input  logic [V_WIDTH-1:0] req_voice,
  input  logic [V_OSC-1:0]   req_osc_mask,
  output logic               req_ready,
  output logic [V_WIDTH-1:0] vx,
  output logic [O_WIDTH-1:0] ox,
  output logic [V_ENVS-1:0]  osc_accum_zero,
  output logic               frame_sync,
  output logic               pending_any
);

  logic [V_OSC-1:0]   pending [VOICES];
  logic [V_OSC-1:0]   active_mask;
  logic               accept;
  logic               last_osc;
  logic               entering;
  logic [V_WIDTH-1:0] vx_next;

  assign accept   = req_valid & req_ready & run;
  assign last_osc = (ox == O_WIDTH'(V_OSC - 1));
  assign entering = run & last_osc;
  assign vx_next  = vx + V_WIDTH'(1);

  // Slot counter, frame marker and the mask latched for the voice pass in progress.
  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      vx          <= '0;
      ox          <= '0;
      frame_sync  <= 1'b0;
      active_mask <= '0;
      req_ready   <= 1'b0;
    end else begin
      req_ready <= 1'b1;
      if (run) begin
        ox         <= ox + O_WIDTH'(1);
        frame_sync <= last_osc && (vx == V_WIDTH'(VOICES - 1));
        if (last_osc) begin
          vx          <= vx_next;
          active_mask <= pending[vx_next];
        end
      end
    end
  end

  // A request landing on the entry edge of its own voice replaces the handed-off
  // bits, so it waits a full frame instead of being applied to a partial pass.
  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      for (int v = 0; v < VOICES; v++) pending[v] <= '0;
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        if (entering && (vx_next == V_WIDTH'(v))) begin
          if (accept && (req_voice == V_WIDTH'(v)))
            pending[v] <= req_osc_mask;
          else
            pending[v] <= '0;
        end else if (accept && (req_voice == V_WIDTH'(v))) begin
          pending[v] <= pending[v] | req_osc_mask;
        end
      end
    end
  end

  always_comb begin
    pending_any = 1'b0;
    for (int v = 0; v < VOICES; v++) pending_any = pending_any | (|pending[v]);
  end

  // Datapath reads bit {ox,0}, so flags sit on even bits only.
  always_comb begin
    osc_accum_zero = '0;
    for (int o = 0; o < V_OSC; o++) osc_accum_zero[2*o] = active_mask[o];
  end

endmodule

// File: tb/tb_nco_voice_scheduler.sv
// Directed bench for nco_voice_scheduler: stimulus queues the expected slot
// state after every edge and a negedge monitor compares it against the DUT.
module tb_nco_voice_scheduler;

  logic       clk;
  logic       reset_reg_N;
  logic       run;
  logic       req_valid;
  logic [2:0] req_voice;
  logic [3:0] req_osc_mask;
  logic       req_ready;
  logic [2:0] vx;
  logic [1:0] ox;
  logic [7:0] osc_accum_zero;
  logic       frame_sync;
  logic       pending_any;

  typedef struct {
    logic [2:0] vx;
    logic [1:0] ox;
    logic [7:0] zero;
    logic       fs;
    logic       pany;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  logic [2:0] t_vx = '0;
  logic [1:0] t_ox = '0;
  logic       t_fs = 1'b0;
  logic       t_rdy = 1'b0;

  nco_voice_scheduler dut (
    .sCLK_XVXENVS  (clk),
    .reset_reg_N   (reset_reg_N),
    .run           (run),
    .req_valid     (req_valid),
    .req_voice     (req_voice),
    .req_osc_mask  (req_osc_mask),
    .req_ready     (req_ready),
    .vx            (vx),
    .ox            (ox),
    .osc_accum_zero(osc_accum_zero),
    .frame_sync    (frame_sync),
    .pending_any   (pending_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  // Monitor: one queued expectation per presented slot.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("vx",    8'(vx),             8'(e.vx));
      checkOutput("ox",    8'(ox),             8'(e.ox));
      checkOutput("zero",  osc_accum_zero,     e.zero);
      checkOutput("fsync", 8'(frame_sync),     8'(e.fs));
      checkOutput("pany",  8'(pending_any),    8'(e.pany));
      checkOutput("ready", 8'(req_ready),      8'(e.rdy));
    end
  end

  task automatic applyStimulus(input logic v, input logic [2:0] voice, input logic [3:0] mask,
                               input logic r, input logic [7:0] ez, input logic ep);
    req_valid    = v;
    req_voice    = voice;
    req_osc_mask = mask;
    run          = r;
    @(posedge clk);
    if (r) begin
      t_fs = (t_ox == 2'd3) && (t_vx == 3'd7);
      if (t_ox == 2'd3) t_vx = t_vx + 3'd1;
      t_ox = t_ox + 2'd1;
    end
    t_rdy = 1'b1;
    exp_q.push_back('{vx: t_vx, ox: t_ox, zero: ez, fs: t_fs, pany: ep, rdy: t_rdy});
    #1;
    req_valid    = 1'b0;
    req_osc_mask = 4'd0;
  endtask

  task automatic idleUntil(input logic [2:0] v, input logic [1:0] o, input logic [7:0] ez, input logic ep);
    int guard = 0;
    while (!(t_vx == v && t_ox == o)) begin
      applyStimulus(1'b0, 3'd0, 4'd0, 1'b1, ez, ep);
      guard++;
      if (guard > 40) begin
        checkOutput("idle_bound", 8'(guard), 8'd40);
        return;
      end
    end
  endtask

  task automatic pushResetExpect();
    t_vx = '0; t_ox = '0; t_fs = 1'b0; t_rdy = 1'b0;
    exp_q.push_back('{vx: 3'd0, ox: 2'd0, zero: 8'h00, fs: 1'b0, pany: 1'b0, rdy: 1'b0});
  endtask

  initial begin
    reset_reg_N  = 1'b0;
    run          = 1'b0;
    req_valid    = 1'b0;
    req_voice    = 3'd0;
    req_osc_mask = 4'd0;
    #1;
    pushResetExpect();
    @(negedge clk);
    @(posedge clk);
    #1 reset_reg_N = 1'b1;

    // Idle frame: ready rises, counter walks 32 slots, one frame_sync at the wrap.
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0, 8'h00, 1'b0);
    idleUntil(3'd7, 2'd3, 8'h00, 1'b0);
    idleUntil(3'd0, 2'd0, 8'h00, 1'b0);

    // Voice 3, mask 0101, accepted at slot (1,2).
    idleUntil(3'd1, 2'd2, 8'h00, 1'b0);
    applyStimulus(1'b1, 3'd3, 4'b0101, 1'b1, 8'h00, 1'b1);
    idleUntil(3'd2, 2'd3, 8'h00, 1'b1);
    idleUntil(3'd3, 2'd3, 8'h11, 1'b0);
    idleUntil(3'd0, 2'd0, 8'h00, 1'b0);
    idleUntil(3'd7, 2'd3, 8'h00, 1'b0);
    idleUntil(3'd0, 2'd0, 8'h00, 1'b0);

    // Two requests to voice 5 OR into one pass.
    applyStimulus(1'b1, 3'd5, 4'b0001, 1'b1, 8'h00, 1'b1);
    applyStimulus(1'b1, 3'd5, 4'b1000, 1'b1, 8'h00, 1'b1);
    idleUntil(3'd4, 2'd3, 8'h00, 1'b1);
    idleUntil(3'd5, 2'd3, 8'h41, 1'b0);
    idleUntil(3'd0, 2'd0, 8'h00, 1'b0);

    // Collision on voice 2 entry edge with pending[2]=0010.
    applyStimulus(1'b1, 3'd2, 4'b0010, 1'b1, 8'h00, 1'b1);
    idleUntil(3'd1, 2'd3, 8'h00, 1'b1);
    applyStimulus(1'b1, 3'd2, 4'b1111, 1'b1, 8'h04, 1'b1);
    idleUntil(3'd2, 2'd3, 8'h04, 1'b1);
    idleUntil(3'd1, 2'd3, 8'h00, 1'b1);
    idleUntil(3'd2, 2'd3, 8'h55, 1'b0);
    idleUntil(3'd0, 2'd0, 8'h00, 1'b0);

    // run=0 at (4,1) with pending[4]=0011; requests while halted are ignored.
    idleUntil(3'd4, 2'd0, 8'h00, 1'b0);
    applyStimulus(1'b1, 3'd4, 4'b0011, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 3'd4, 4'b1100, 1'b0, 8'h00, 1'b1);
    idleUntil(3'd3, 2'd3, 8'h00, 1'b1);
    idleUntil(3'd4, 2'd3, 8'h05, 1'b0);
    idleUntil(3'd0, 2'd0, 8'h00, 1'b0);

    // Reset at (6,2) with pending[7]=1111 discards the request.
    applyStimulus(1'b1, 3'd7, 4'b1111, 1'b1, 8'h00, 1'b1);
    idleUntil(3'd6, 2'd2, 8'h00, 1'b1);
    @(negedge clk);
    #1 reset_reg_N = 1'b0;
    #1 pushResetExpect();
    @(negedge clk);
    @(posedge clk);
    #1 reset_reg_N = 1'b1;
    idleUntil(3'd7, 2'd3, 8'h00, 1'b0);
    idleUntil(3'd0, 2'd0, 8'h00, 1'b0);
    idleUntil(3'd7, 2'd3, 8'h00, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) checkOutput("drain", 8'(exp_q.size()), 8'd0);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
